// File: rtl/conv_pass_sched.sv
// conv_pass_sched: frame-level sequencer for the 5x5 convolution engine.
// Runs one pass per kernel: flush engine, stream the image from pixel SRAM
// in raster order, and capture every engine result into the result SRAM
// at kernel*OUT_PER_K + index.
module conv_pass_sched #(
    parameter int word_length   = 8,
    parameter int image_size    = 28,
    parameter int kernel_size   = 5,
    parameter int KW            = 2,
    parameter int IMG_AW        = 10,
    parameter int RES_AW        = 12,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [KW:0]              num_kern,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     img_ren,
    output logic [IMG_AW-1:0]        img_addr,
    input  logic [word_length-1:0]   img_rdata,
    output logic                     eng_clr,
    output logic [KW-1:0]            eng_wsel,
    output logic                     eng_in_valid,
    output logic [word_length-1:0]   eng_data_in,
    input  logic                     eng_out_valid,
    input  logic [2*word_length-1:0] eng_result,
    output logic                     res_we,
    output logic [RES_AW-1:0]        res_addr,
    output logic [2*word_length-1:0] res_wdata
);

    localparam int OUT_SIDE  = image_size - (kernel_size - 1);
    localparam int OUT_PER_K = OUT_SIDE * OUT_SIDE;
    localparam int NPIX      = image_size * image_size;
    localparam int OW        = $clog2(OUT_PER_K + 1);
    localparam int TW        = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [IMG_AW-1:0] LAST_PIX = IMG_AW'(NPIX - 1);
    localparam logic [OW-1:0]     OUT_FULL = OW'(OUT_PER_K);
    localparam logic [TW-1:0]     TO_MAX   = TW'(DRAIN_TIMEOUT);
    localparam logic [KW:0]       NK_ONE   = (KW+1)'(1);
    localparam logic [KW:0]       NK_MAX   = (KW+1)'(2**KW);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [KW:0]              nk_reg, nk_clamped;
    logic [KW-1:0]            kidx_reg;
    logic [IMG_AW-1:0]        pix_cnt_reg;
    logic [OW-1:0]            out_cnt_reg;
    logic [TW-1:0]            to_cnt_reg;
    logic                     err_reg;
    logic                     eng_in_valid_reg;
    logic                     res_we_reg;
    logic [RES_AW-1:0]        res_addr_reg;
    logic [RES_AW-1:0]        res_addr_calc;
    logic [2*word_length-1:0] res_wdata_reg;
    logic                     kidx_last, out_full, timed_out, in_pass, capture;

    // Clamp the requested kernel count into 1 .. 2**KW
    always_comb begin
        nk_clamped = num_kern;
        if (num_kern == '0)
            nk_clamped = NK_ONE;
        else if (num_kern > NK_MAX)
            nk_clamped = NK_MAX;
    end

    assign kidx_last     = ({1'b0, kidx_reg} == (nk_reg - NK_ONE));
    assign out_full      = (out_cnt_reg == OUT_FULL);
    assign timed_out     = (to_cnt_reg == TO_MAX);
    assign in_pass       = (state_reg == S_FEED) || (state_reg == S_DRAIN);
    // Abort kills a capture in the same cycle; one already registered finishes.
    assign capture       = in_pass && eng_out_valid && (out_cnt_reg < OUT_FULL) && !abort;
    assign res_addr_calc = RES_AW'(kidx_reg) * RES_AW'(OUT_PER_K) + RES_AW'(out_cnt_reg);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic; abort outranks every other transition outside IDLE
    always_comb begin
        state_next = state_reg;
        if (abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (start) state_next = S_CLEAR;
                S_CLEAR: state_next = S_FEED;
                S_FEED:  if (pix_cnt_reg == LAST_PIX) state_next = S_DRAIN;
                S_DRAIN: if (out_full || timed_out) state_next = S_NEXT;
                S_NEXT:  state_next = kidx_last ? S_DONE : S_CLEAR;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        busy    = (state_reg != S_IDLE);
        done    = (state_reg == S_DONE);
        img_ren = (state_reg == S_FEED);
        eng_clr = (state_reg == S_CLEAR);
    end

    // Counters, kernel index, error flag, pixel strobe and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nk_reg           <= NK_ONE;
            kidx_reg         <= '0;
            pix_cnt_reg      <= '0;
            out_cnt_reg      <= '0;
            to_cnt_reg       <= '0;
            err_reg          <= 1'b0;
            eng_in_valid_reg <= 1'b0;
            res_we_reg       <= 1'b0;
            res_addr_reg     <= '0;
            res_wdata_reg    <= '0;
        end else begin
            eng_in_valid_reg <= img_ren && !abort;
            res_we_reg       <= capture;
            if (capture) begin
                res_addr_reg  <= res_addr_calc;
                res_wdata_reg <= eng_result;
                out_cnt_reg   <= out_cnt_reg + OW'(1);
            end
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        nk_reg   <= nk_clamped;
                        kidx_reg <= '0;
                        err_reg  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    pix_cnt_reg <= '0;
                    out_cnt_reg <= '0;
                    to_cnt_reg  <= '0;
                end
                S_FEED: begin
                    pix_cnt_reg <= pix_cnt_reg + IMG_AW'(1);
                end
                S_DRAIN: begin
                    if (eng_out_valid)
                        to_cnt_reg <= '0;
                    else if (!timed_out)
                        to_cnt_reg <= to_cnt_reg + TW'(1);
                    if (timed_out && !out_full && !abort)
                        err_reg <= 1'b1;
                end
                S_NEXT: begin
                    if (!kidx_last && !abort)
                        kidx_reg <= kidx_reg + KW'(1);
                end
                default: ;
            endcase
        end
    end

    assign err          = err_reg;
    assign img_addr     = pix_cnt_reg;
    assign eng_wsel     = kidx_reg;
    assign eng_in_valid = eng_in_valid_reg;
    // Pixel path is combinational from the SRAM; held at zero between strobes.
    assign eng_data_in  = eng_in_valid_reg ? img_rdata : '0;
    assign res_we       = res_we_reg;
    assign res_addr     = res_addr_reg;
    assign res_wdata    = res_wdata_reg;

endmodule

// File: tb/tb_conv_pass_sched.sv
// tb_conv_pass_sched: randomized scheduler bench. A behavioural engine model
// emits result strobes after row/col 4 of each streamed image; every strobe
// that the scheduler must keep is queued with its expected address, and a
// separate monitor pops and compares on every result-SRAM write.
module tb_conv_pass_sched;

    localparam int WL     = 8;
    localparam int IMG    = 28;
    localparam int KS     = 5;
    localparam int KW     = 2;
    localparam int IMG_AW = 10;
    localparam int RES_AW = 12;
    localparam int TMO    = 1024;
    localparam int OSIDE  = IMG - (KS - 1);
    localparam int OPK    = OSIDE * OSIDE;
    localparam int NPIX   = IMG * IMG;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [KW:0]       num_kern;
    logic              busy, done, err, img_ren;
    logic [IMG_AW-1:0] img_addr;
    logic [WL-1:0]     img_rdata = '0;
    logic              eng_clr;
    logic [KW-1:0]     eng_wsel;
    logic              eng_in_valid;
    logic [WL-1:0]     eng_data_in;
    logic              eng_out_valid;
    logic [2*WL-1:0]   eng_result;
    logic              res_we;
    logic [RES_AW-1:0] res_addr;
    logic [2*WL-1:0]   res_wdata;

    conv_pass_sched #(
        .word_length(WL), .image_size(IMG), .kernel_size(KS), .KW(KW),
        .IMG_AW(IMG_AW), .RES_AW(RES_AW), .DRAIN_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_kern(num_kern),
        .busy(busy), .done(done), .err(err), .img_ren(img_ren), .img_addr(img_addr),
        .img_rdata(img_rdata), .eng_clr(eng_clr), .eng_wsel(eng_wsel),
        .eng_in_valid(eng_in_valid), .eng_data_in(eng_data_in),
        .eng_out_valid(eng_out_valid), .eng_result(eng_result),
        .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel SRAM model: registered read, one cycle latency
    logic [WL-1:0] pix_mem [0:1023];
    always @(posedge clk) if (img_ren) img_rdata <= pix_mem[img_addr];

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int passes = 0;

    function automatic void check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endfunction

    // Engine-model controls (written by the stimulus process only)
    int strobe_target = OPK;
    bit mute = 1'b0;

    // Engine-model state (written by the engine process only)
    int pending = 0, emitted = 0, pix_seen = 0, kern_seen = -1;

    // Monitor state (written by the monitor process only)
    int done_cnt = 0, ren_cnt = 0, clr_cnt = 0, wr_cnt = 0;
    int last_we_cyc = 0, done_cyc = 0, clr_cyc = 0, exp_addr = 0;
    bit in_first = 1'b0;

    // Behavioural engine: each pixel at row>=4, col>=4 yields one result;
    // results leave at a random 3/4 rate; strobe_target caps/extends the count.
    initial begin : engine
        eng_out_valid = 1'b0;
        eng_result    = '0;
        forever begin
            @(negedge clk);
            if (rst || !busy) begin
                pending = 0; emitted = 0; kern_seen = -1;
                eng_out_valid = 1'b0;
                continue;
            end
            if (eng_clr) begin
                pix_seen = 0; pending = 0; emitted = 0;
                kern_seen++;
                check("wsel_at_clr", eng_wsel, kern_seen);
            end
            if (eng_in_valid && pix_seen < NPIX) begin
                check("pixel_data", eng_data_in, pix_mem[pix_seen]);
                if ((pix_seen / IMG) >= KS - 1 && (pix_seen % IMG) >= KS - 1) pending++;
                pix_seen++;
                if (pix_seen == NPIX && strobe_target > OPK) pending += strobe_target - OPK;
            end
            if (!mute && pending > 0 && emitted < strobe_target && $urandom_range(3) != 0) begin
                eng_out_valid = 1'b1;
                eng_result    = (2*WL)'($urandom);
                pending--;
                emitted++;
                if (emitted <= OPK)
                    exp_q.push_back('{kern_seen * OPK + emitted - 1, int'(eng_result), cyc});
            end else begin
                eng_out_valid = 1'b0;
            end
        end
    end

    // Monitor: address sequence, timeline, and scoreboard pop on each write
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                continue;
            end
            if (eng_clr) begin
                exp_addr = 0; clr_cyc = cyc; clr_cnt++; in_first = 1'b1;
            end
            if (img_ren) begin
                if (exp_addr == 0) check("feed_start_cycle", cyc, clr_cyc + 1);
                check("img_addr", img_addr, exp_addr);
                exp_addr++;
                ren_cnt++;
            end
            if (eng_in_valid && in_first) begin
                check("in_valid_start_cycle", cyc, clr_cyc + 2);
                in_first = 1'b0;
            end
            if (res_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", res_addr, res_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", res_addr, e.addr);
                    check("wr_data", res_wdata, e.data);
                    check("wr_latency", cyc, e.cyc + 1);
                end
                last_we_cyc = cyc;
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int start_cyc = 0;
    int d0, r0, c0, w0, n;

    task automatic step(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int nk, input bit with_abort);
        num_kern  = (KW+1)'(nk);
        start     = 1'b1;
        abort     = with_abort;
        start_cyc = cyc;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        check("clr_cycle1", eng_clr, 1);
        check("busy_cycle1", busy, 1);
        check("wsel_cycle1", eng_wsel, 0);
        check("err_cleared_on_start", err, 0);
    endtask

    task automatic wait_done(input int base, input int budget);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            step(1);
            k++;
        end
        check("done_pulses", done_cnt - base, 1);
        step(1);
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_err"}, err, 0);
        check({pfx, "_img_ren"}, img_ren, 0);
        check({pfx, "_img_addr"}, img_addr, 0);
        check({pfx, "_eng_clr"}, eng_clr, 0);
        check({pfx, "_eng_wsel"}, eng_wsel, 0);
        check({pfx, "_eng_in_valid"}, eng_in_valid, 0);
        check({pfx, "_eng_data_in"}, eng_data_in, 0);
        check({pfx, "_res_we"}, res_we, 0);
        check({pfx, "_res_addr"}, res_addr, 0);
        check({pfx, "_res_wdata"}, res_wdata, 0);
    endtask

    task automatic snap();
        d0 = done_cnt; r0 = ren_cnt; c0 = clr_cnt; w0 = wr_cnt;
    endtask

    initial begin : stim
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_kern = '0;
        for (int i = 0; i < 1024; i++) pix_mem[i] = WL'($urandom);
        step(3);
        check_all_zero("reset");
        rst = 1'b0;
        step(2);

        // Single kernel, exact result count
        strobe_target = OPK;
        snap();
        do_start(1, 1'b0);
        wait_done(d0, 6000);
        check("k1_writes", wr_cnt - w0, OPK);
        check("k1_img_ren", ren_cnt - r0, NPIX);
        check("k1_done_after_last_write", done_cyc, last_we_cyc + 2);
        check("k1_err", err, 0);
        check("k1_queue_empty", exp_q.size(), 0);
        $display("single kernel: %0d writes, done at +%0d", wr_cnt - w0, done_cyc - start_cyc);

        // Three kernels; start arrives together with abort while idle
        snap();
        do_start(3, 1'b1);
        wait_done(d0, 6000);
        check("k3_clr_pulses", clr_cnt - c0, 3);
        check("k3_img_ren", ren_cnt - r0, 3 * NPIX);
        check("k3_writes", wr_cnt - w0, 3 * OPK);
        check("k3_done_after_last_write", done_cyc, last_we_cyc + 2);
        check("k3_queue_empty", exp_q.size(), 0);
        $display("three kernels: %0d writes, %0d img reads", wr_cnt - w0, ren_cnt - r0);

        // Start while busy is ignored
        snap();
        do_start(1, 1'b0);
        step(400);
        num_kern = 3'd3;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(d0, 6000);
        check("busy_start_clr", clr_cnt - c0, 1);
        check("busy_start_img_ren", ren_cnt - r0, NPIX);
        check("busy_start_writes", wr_cnt - w0, OPK);
        $display("start while busy: %0d passes", clr_cnt - c0);

        // Abort at FEED address 300, then restart with num_kern=0 (treated as 1)
        snap();
        do_start(1, 1'b0);
        n = 0;
        while (!(img_ren && img_addr == 299) && n < 2000) begin
            step(1);
            n++;
        end
        check("abort_reach_299", img_addr, 299);
        mute = 1'b1;
        step(1);
        check("abort_addr_300", img_addr, 300);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        mute  = 1'b0;
        check("abort_img_ren", img_ren, 0);
        check("abort_in_valid", eng_in_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_res_we", res_we, 0);
        step(5);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_queue_empty", exp_q.size(), 0);
        snap();
        do_start(0, 1'b0);
        wait_done(d0, 6000);
        check("restart_clr", clr_cnt - c0, 1);
        check("restart_writes", wr_cnt - w0, OPK);
        $display("abort: restart produced %0d writes", wr_cnt - w0);

        // Silent engine: drain timeout, sticky err, cleared by next start
        strobe_target = 100;
        snap();
        do_start(1, 1'b0);
        wait_done(d0, 6000);
        check("silent_writes", wr_cnt - w0, 100);
        check("silent_err", err, 1);
        check("silent_done_cycle", done_cyc - start_cyc, 1 + NPIX + 1 + TMO + 2);
        $display("silent engine: err=%0d, done at +%0d", err, done_cyc - start_cyc);

        // num_kern=7 clamps to 4 kernels; err must clear on this start
        strobe_target = OPK;
        snap();
        do_start(7, 1'b0);
        wait_done(d0, 12000);
        check("clamp_clr", clr_cnt - c0, 4);
        check("clamp_writes", wr_cnt - w0, 4 * OPK);
        check("clamp_err", err, 0);
        $display("clamp: %0d passes, %0d writes", clr_cnt - c0, wr_cnt - w0);

        // Overrun: 580 strobes, only 576 kept
        strobe_target = OPK + 4;
        snap();
        do_start(1, 1'b0);
        wait_done(d0, 6000);
        check("overrun_writes", wr_cnt - w0, OPK);
        check("overrun_done_after_last_write", done_cyc, last_we_cyc + 2);
        step(3);
        check("overrun_no_late_write", wr_cnt - w0, OPK);
        $display("overrun: %0d writes", wr_cnt - w0);

        // Asynchronous reset in the middle of DRAIN
        strobe_target = OPK;
        snap();
        do_start(1, 1'b0);
        n = 0;
        while ((ren_cnt - r0) < NPIX && n < 2000) begin
            step(1);
            n++;
        end
        step(3);
        check("drain_busy_before_rst", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        step(2);
        rst = 1'b0;
        step(2);
        check("midrst_no_done", done_cnt - d0, 0);
        $display("mid-drain reset: busy=%0d", busy);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
